alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Arbitration and sequencing controller that shares one 16-bit add/subtract ALU between two requesters.
- The ALU produces Sign, Zero, Carry, Parity and Overflow flags.
- Grants requesters round-robin, latches the operands, runs the operation, then returns a registered result, flags and a completion pulse to the owning requester.
- Sits between two datapath clients and the ALU, which is instantiated inside this block.

Parameters:
- WIDTH, 16, operand/result width in bits; all flag rules below use bit WIDTH-1 as the sign bit.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 operation request; held until gnt0
- op0  input  1  requester 0 operation: 0 = X+Y, 1 = X-Y
- x0, y0  input  WIDTH  requester 0 operands
- req1, op1, x1, y1  input  1/1/WIDTH/WIDTH  requester 1 equivalents
- gnt0, gnt1  output  1  one-cycle pulse: operands of that requester latched
- done0, done1  output  1  one-cycle pulse: result for that requester valid
- z  output  WIDTH  registered result
- sign, zero, carry, parity, overflow  output  1  registered flags of z
- busy  output  1  high while state is not IDLE
- owner  output  1  index of the requester being served or last served

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state IDLE, round-robin pointer prio=0.
  - gnt0/1, done0/1, busy, owner all 0.
  - z=0; all flags 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester equal to prio.
  - On a grant at edge N: latch x/y/op of the winner; set owner; pulse gnt of the winner for the cycle after edge N; go to EXEC.
- EXEC, at edge N+1:
  - Compute on the latched operands only; input changes after the grant have no effect.
  - Register z and flags; pulse done[owner] for one cycle; go to RESP.
- RESP, at edge N+2:
  - Set prio to the index not equal to owner; go to IDLE.
  - done drops.
  - z and flags hold until the next EXEC.
- Timing summary:
  - Latency from req sampled to done high: 2 edges.
  - Earliest next grant: edge N+3, so throughput is 1 operation per 3 cycles.
- Request handling:
  - req is sampled only in IDLE.
  - A req high during EXEC/RESP waits; no grant is lost.
  - A req dropped before its grant is simply not served.
  - Requester must deassert req the cycle after gnt, or it will be re-served.
- Arithmetic (WIDTH+1-bit sum):
  - Add: {carry,z} = X + Y.
  - Sub: {carry,z} = X + ~Y + 1, so carry=1 means no borrow.
- Flags:
  - sign = z[WIDTH-1].
  - zero = (z==0).
  - parity = XNOR-reduce of z, i.e. 1 when the count of ones is even.
  - overflow, with Y' = Y for add and ~Y for sub: (X[msb]&Y'[msb]&~z[msb]) | (~X[msb]&~Y'[msb]&z[msb]).
- Reset mid-operation (rst in EXEC or RESP): operation abandoned; no done is issued; all registers return to reset values, including prio=0.
- Outputs never show gnt0&gnt1 or done0&done1 in the same cycle.
- busy = (state != IDLE).

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; busy 0.
- req0=1, op0=0, x0=8FFF, y0=8000 -> gnt0 1 cycle after the sampling edge, done0 one cycle later:
  - z=0FFF
  - carry=1, overflow=1, sign=0, zero=0, parity=1
- req1 add, FFFE+0002 -> z=0000, carry=1, zero=1, parity=1, overflow=0, sign=0.
- req1 add, AAAA+5555 -> z=FFFF, sign=1, parity=1, carry=0, zero=0, overflow=0.
- Subtract cases on requester 0:
  - 0005-0007 -> z=FFFE, carry=0, sign=1, parity=0, overflow=0.
  - 8000-0001 -> z=7FFF, overflow=1, carry=1, sign=0, parity=0.
- Fairness and robustness:
  - req0 and req1 held high together from reset for 4 operations -> grant order 0,1,0,1, with gnt 3 cycles apart.
  - Change x0 in the cycle after gnt0 -> result unaffected.
  - Assert rst during EXEC -> no done; all outputs 0.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-client arbiter/sequencer around a shared add/subtract ALU.
// One operation per three cycles: grant+latch, execute, respond.

// Combinational add/subtract unit with status flags.
module alu_share_alu #(
    parameter int WIDTH = 16
) (
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   sum;

    // Subtract is X + ~Y + 1, so carry out means "no borrow".
    always_comb begin
        y_eff    = op ? ~y : y;
        sum      = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, op};
        z        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        sign     = z[WIDTH-1];
        zero     = (z == '0);
        parity   = ~^z;
        overflow = (x[WIDTH-1] & y_eff[WIDTH-1] & ~z[WIDTH-1]) |
                   (~x[WIDTH-1] & ~y_eff[WIDTH-1] & z[WIDTH-1]);
    end
endmodule

module alu_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow,
    output logic             busy,
    output logic             owner
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic             op;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } opnd_t;

    state_t           state;
    logic             prio;
    logic             pick;
    opnd_t            opnd;
    logic [WIDTH-1:0] alu_z;
    logic             alu_sign, alu_zero, alu_carry, alu_parity, alu_overflow;

    // Winner of the IDLE-cycle arbitration: the lone requester, or prio on a tie.
    always_comb begin
        pick = (req0 && req1) ? prio : req1;
    end

    alu_share_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (opnd.op),
        .x        (opnd.x),
        .y        (opnd.y),
        .z        (alu_z),
        .sign     (alu_sign),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .parity   (alu_parity),
        .overflow (alu_overflow)
    );

    // Sequencer: grant/latch in IDLE, register result in EXEC, rotate priority in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            opnd     <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            owner    <= 1'b0;
            z        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        opnd  <= pick ? opnd_t'{op1, x1, y1} : opnd_t'{op0, x0, y0};
                        owner <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    z        <= alu_z;
                    sign     <= alu_sign;
                    zero     <= alu_zero;
                    carry    <= alu_carry;
                    parity   <= alu_parity;
                    overflow <= alu_overflow;
                    done0    <= ~owner;
                    done1    <= owner;
                    state    <= RESP;
                end
                RESP: begin
                    prio  <= ~owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed spec cases plus a
// randomized run against an arithmetic reference model.
module tb_alu_share_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, req0, op0, req1, op1;
    logic [W-1:0] x0, y0, x1, y1;
    logic         gnt0, gnt1, done0, done1;
    logic [W-1:0] z;
    logic         sign, zero, carry, parity, overflow, busy, owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .x0(x0), .y0(y0),
        .req1(req1), .op1(op1), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .z(z), .sign(sign), .zero(zero), .carry(carry), .parity(parity),
        .overflow(overflow), .busy(busy), .owner(owner)
    );

    typedef struct {
        logic [15:0] z;
        logic [4:0]  f;   // {sign, zero, carry, parity, overflow}
    } res_t;

    // Reference: plain integer arithmetic, overflow as signed out-of-range.
    function automatic res_t model(input logic op, input logic [15:0] x, input logic [15:0] y);
        int          xs, ys, r;
        logic [31:0] u;
        res_t        m;
        xs = int'($signed(x));
        ys = int'($signed(y));
        if (!op) begin
            u = {16'b0, x} + {16'b0, y};
            r = xs + ys;
        end else begin
            u = {16'b0, x} + 32'h10000 - {16'b0, y};
            r = xs - ys;
        end
        m.z = u[15:0];
        m.f = {m.z[15], (m.z == 16'h0), u[16], ($countones(m.z) % 2 == 0), (r > 32767 || r < -32768)};
        return m;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        repeat (5) begin
            tick();
            n_vec++;
            if ({gnt0, gnt1, done0, done1, busy, owner, z, sign, zero, carry, parity, overflow} !== '0) begin
                n_err++;
                $display("FAIL reset_idle: outputs=%h required all zero",
                         {gnt0, gnt1, done0, done1, busy, owner, z, sign, zero, carry, parity, overflow});
            end
        end
    endtask

    // Single operation from idle with expected values given as constants.
    task automatic test_op(input string name, input logic who, input logic op,
                           input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] ez, input logic [4:0] ef);
        if (who) begin req1 = 1; op1 = op; x1 = x; y1 = y; end
        else     begin req0 = 1; op0 = op; x0 = x; y0 = y; end
        tick();
        n_vec++;
        if ({gnt0, gnt1, busy} !== {~who, who, 1'b1}) begin
            n_err++;
            $display("FAIL %s_gnt: gnt0/gnt1/busy=%b%b%b required %b%b1", name, gnt0, gnt1, busy, ~who, who);
        end
        req0 = 0; req1 = 0;
        tick();
        n_vec++;
        if ({done0, done1, owner} !== {~who, who, who} || z !== ez ||
            {sign, zero, carry, parity, overflow} !== ef) begin
            n_err++;
            $display("FAIL %s_done: done=%b%b owner=%b z=%h flags=%b required done=%b%b owner=%b z=%h flags=%b",
                     name, done0, done1, owner, z, {sign, zero, carry, parity, overflow}, ~who, who, who, ez, ef);
        end
        tick();
        n_vec++;
        if ({done0, done1, busy} !== 3'b000 || z !== ez) begin
            n_err++;
            $display("FAIL %s_resp: done=%b%b busy=%b z=%h required 000 z=%h", name, done0, done1, busy, z, ez);
        end
    endtask

    task automatic test_arith;
        // flags order: sign zero carry parity overflow
        test_op("add_8fff_8000", 1'b0, 1'b0, 16'h8FFF, 16'h8000, 16'h0FFF, 5'b00111);
        test_op("add_fffe_0002", 1'b1, 1'b0, 16'hFFFE, 16'h0002, 16'h0000, 5'b01110);
        test_op("add_aaaa_5555", 1'b1, 1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 5'b10010);
        test_op("sub_0005_0007", 1'b0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 5'b10000);
        test_op("sub_8000_0001", 1'b0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00101);
    endtask

    // Both requesters held from reset: grants alternate 0,1,0,1 three cycles apart.
    task automatic test_back_to_back;
        idle_inputs();
        rst = 1; req0 = 1; req1 = 1;
        tick();
        rst = 0;
        for (int c = 0; c < 12; c++) begin
            logic e0, e1;
            tick();
            e0 = (c % 6 == 0);
            e1 = (c % 6 == 3);
            n_vec++;
            if ({gnt0, gnt1} !== {e0, e1}) begin
                n_err++;
                $display("FAIL rr_order c=%0d: gnt0/gnt1=%b%b required %b%b", c, gnt0, gnt1, e0, e1);
            end
        end
        req0 = 0; req1 = 0;
        tick(); tick(); tick();
    endtask

    // Operands changed right after the grant must not affect the result.
    task automatic test_latch;
        idle_inputs();
        req0 = 1; x0 = 16'h0001; y0 = 16'h0002;
        tick();
        req0 = 0; op0 = 1; x0 = 16'h1234; y0 = 16'h4321;
        tick();
        n_vec++;
        if (done0 !== 1'b1 || z !== 16'h0003) begin
            n_err++;
            $display("FAIL latch: done0=%b z=%h required done0=1 z=0003", done0, z);
        end
        tick();
    endtask

    // Reset while serving requester 1 kills the done and resets priority to 0.
    task automatic test_reset_mid;
        idle_inputs();
        test_op("pre_mid", 1'b0, 1'b0, 16'h0010, 16'h0020, 16'h0030, 5'b00010);
        req1 = 1; x1 = 16'h7777; y1 = 16'h1111;
        tick();
        req1 = 0; rst = 1;
        tick();
        n_vec++;
        if ({gnt0, gnt1, done0, done1, busy, owner, z, sign, zero, carry, parity, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: outputs=%h required all zero",
                     {gnt0, gnt1, done0, done1, busy, owner, z, sign, zero, carry, parity, overflow});
        end
        rst = 0; req0 = 1; req1 = 1;
        tick();
        n_vec++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_prio: gnt0/gnt1=%b%b required 10", gnt0, gnt1);
        end
        req0 = 0; req1 = 0;
        tick(); tick();
    endtask

    // Random traffic against a timing/arbitration model written from the rules.
    task automatic test_random;
        logic        prio_m, owner_m, s0, s1, sop0, sop1, win, eg, ebusy, edone;
        logic [15:0] sx0, sy0, sx1, sy1;
        int          t;
        res_t        exp_r;
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        prio_m = 0; owner_m = 0; t = 2;
        exp_r.z = '0; exp_r.f = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!req0) begin
                op0 = 1'($urandom); x0 = 16'($urandom); y0 = 16'($urandom);
                req0 = ($urandom_range(99) < 30);
            end else if ($urandom_range(99) < 3) req0 = 0;
            else if ($urandom_range(99) < 20) begin x0 = 16'($urandom); op0 = 1'($urandom); end
            if (!req1) begin
                op1 = 1'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
                req1 = ($urandom_range(99) < 30);
            end else if ($urandom_range(99) < 3) req1 = 0;
            else if ($urandom_range(99) < 20) begin y1 = 16'($urandom); op1 = 1'($urandom); end
            if ($urandom_range(99) < 5) begin x0 = 16'h8000; y0 = 16'h7FFF; x1 = 16'hFFFF; y1 = 16'h0001; end
            s0 = req0; s1 = req1; sop0 = op0; sop1 = op1;
            sx0 = x0; sy0 = y0; sx1 = x1; sy1 = y1;
            tick();
            t = (t < 3) ? t + 1 : 3;
            eg  = (t >= 3) && (s0 || s1);
            win = (s0 && s1) ? prio_m : s1;
            if (eg) begin
                t = 0;
                owner_m = win;
                prio_m = ~win;
                exp_r = win ? model(sop1, sx1, sy1) : model(sop0, sx0, sy0);
            end
            ebusy = (t <= 1);
            edone = (t == 1);
            n_vec++;
            if ({gnt0, gnt1, done0, done1, busy, owner} !==
                {eg & ~win, eg & win, edone & ~owner_m, edone & owner_m, ebusy, owner_m}) begin
                n_err++;
                $display("FAIL rand_ctrl c=%0d: gnt=%b%b done=%b%b busy=%b owner=%b required gnt=%b%b done=%b%b busy=%b owner=%b",
                         c, gnt0, gnt1, done0, done1, busy, owner,
                         eg & ~win, eg & win, edone & ~owner_m, edone & owner_m, ebusy, owner_m);
            end
            if (edone) begin
                n_vec++;
                if (z !== exp_r.z || {sign, zero, carry, parity, overflow} !== exp_r.f) begin
                    n_err++;
                    $display("FAIL rand_result c=%0d: z=%h flags=%b required z=%h flags=%b",
                             c, z, {sign, zero, carry, parity, overflow}, exp_r.z, exp_r.f);
                end
            end
            if (eg) begin
                if (win) req1 = 0;
                else     req0 = 0;
            end
        end
        req0 = 0; req1 = 0;
        tick(); tick(); tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_arith();
        test_back_to_back();
        test_latch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
